// File: rtl/ccff_loader_pkg.sv
// ---------------------------------------------------------------------------
// ccff_loader_pkg
// Shared types and helpers for the configuration-chain loader.
//   state_t          : loader FSM states
//   words_per_chain  : number of host words needed to cover a chain,
//                      i.e. ceil(chain_len / word_w)
// ---------------------------------------------------------------------------
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic int words_per_chain(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// ---------------------------------------------------------------------------
// ccff_word_serializer
// Single-word buffer that turns host words into a bit stream, LSB first.
//   clk, srst  : clock, synchronous active-high reset
//   active     : owner is in a shifting pass and the chain still has room
//   final_bit  : the bit shifted this cycle is the last one of the chain;
//                the rest of the buffered word is dropped
//   s_valid/s_data/s_ready : host word stream
//   shift      : a bit leaves the buffer this cycle
//   bit_out    : the bit leaving the buffer (meaningful when shift = 1)
// ---------------------------------------------------------------------------
module ccff_word_serializer #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              active,
    input  logic              final_bit,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_ready,
    output logic              shift,
    output logic              bit_out
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] word_buf_reg;
    logic              buf_vld_reg;
    logic [IDX_W-1:0]  bit_idx_reg;

    logic last_word_bit;
    logic accept;

    assign last_word_bit = (bit_idx_reg == IDX_W'(WORD_W - 1));

    assign shift   = active && buf_vld_reg;
    assign bit_out = word_buf_reg[bit_idx_reg];

    // Refill in the same cycle the last bit of a word leaves, so words
    // stream with no bubble. On the chain's final bit the buffer is flushed
    // instead, so no refill is offered then: a word taken in that cycle
    // would be thrown away.
    assign s_ready = active && (!buf_vld_reg || (shift && last_word_bit && !final_bit));
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (srst) begin
            word_buf_reg <= '0;
            buf_vld_reg  <= 1'b0;
            bit_idx_reg  <= '0;
        end else if (accept) begin
            word_buf_reg <= s_data;
            buf_vld_reg  <= 1'b1;
            bit_idx_reg  <= '0;
        end else if (shift) begin
            if (last_word_bit || final_bit) begin
                buf_vld_reg <= 1'b0;
                bit_idx_reg <= '0;
            end else begin
                bit_idx_reg <= bit_idx_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
// Drives a configuration flip-flop chain from a host word stream. Words are
// serialised LSB first onto ccff_head with config_enable high on every shift
// cycle. Build option CCFF_READBACK_CHECK_EN adds a second pass in which the
// host re-sends the bitstream and ccff_tail is compared bit by bit.
//
// Parameters: WORD_W (host word width), CHAIN_LEN (chain bits),
//             CNT_W (bit counter width)
// Ports:
//   prog_clk      : clock shared with the chain
//   pReset        : synchronous active-high reset
//   start         : begin a load (only looked at in IDLE)
//   s_valid/s_data/s_ready : host word stream, bit 0 shifted first
//   config_enable : chain shift enable, high exactly on shift cycles
//   ccff_head     : serial data into the chain (holds when not shifting)
//   ccff_tail     : serial data from the end of the chain (verify only)
//   busy          : not idle
//   done          : one-cycle pulse after the last shift
//   err           : sticky verify mismatch, cleared by start
// ---------------------------------------------------------------------------
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 36,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_ready,
    output logic              config_enable,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             head_reg;

    logic in_pass;
    logic final_bit;
    logic shift;
    logic ser_bit;

    // A pass covers exactly CHAIN_LEN shifts; the counter restarts for the
    // verify pass.
    assign in_pass   = ((state_reg == ST_LOAD) || (state_reg == ST_VERIFY)) &&
                       (cnt_reg < CNT_W'(CHAIN_LEN));
    assign final_bit = (cnt_reg == CNT_W'(CHAIN_LEN - 1));

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .clk       (prog_clk),
        .srst      (pReset),
        .active    (in_pass),
        .final_bit (final_bit),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .shift     (shift),
        .bit_out   (ser_bit)
    );

    assign config_enable = shift;
    // Between shifts the head keeps the last bit driven into the chain.
    assign ccff_head     = shift ? ser_bit : head_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign done          = (state_reg == ST_DONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (shift && final_bit) begin
`ifdef CCFF_READBACK_CHECK_EN
                    state_next = ST_VERIFY;
`else
                    state_next = ST_DONE;
`endif
                end
            end
            ST_VERIFY: begin
                if (shift && final_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            head_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_IDLE) && start) begin
                cnt_reg <= '0;
            end else if (shift) begin
                cnt_reg <= final_bit ? '0 : cnt_reg + 1'b1;
            end
            if (shift) begin
                head_reg <= ser_bit;
            end
        end
    end

`ifdef CCFF_READBACK_CHECK_EN
    logic err_reg;

    // ccff_tail is sampled before the edge, so it shows the oldest bit in
    // the chain, which is the one the host is re-sending right now.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            err_reg <= 1'b0;
        end else if ((state_reg == ST_IDLE) && start) begin
            err_reg <= 1'b0;
        end else if ((state_reg == ST_VERIFY) && shift && (ccff_tail != ser_bit)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_chain_loader
// Bench for ccff_chain_loader: a table of load scenarios for an 8-bit/36-bit
// loader with a shift-register model of the chain, a queue of expected head
// bits popped on every shift, plus hand sequences for reset mid-load and a
// 4-bit/13-bit loader.
// ---------------------------------------------------------------------------
module tb_ccff_chain_loader;
    import ccff_loader_pkg::*;

    localparam int W  = 8;
    localparam int L  = 36;
    localparam int WB = 4;
    localparam int LB = 13;
`ifdef CCFF_READBACK_CHECK_EN
    localparam int PASSES    = 2;
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam int PASSES    = 1;
    localparam bit VERIFY_EN = 1'b0;
`endif
    localparam int NWORDS  = words_per_chain(L, W);
    localparam int NWORDSB = words_per_chain(LB, WB);

    logic         clk = 1'b0;
    logic         p_reset;
    logic         start, s_valid, s_ready, cfg_en, head, tail, busy, done, err;
    logic [W-1:0] s_data;
    logic         start_b, s_valid_b, s_ready_b, en_b, head_b, busy_b, done_b, err_b;
    logic         tail_b = 1'b0;
    logic [WB-1:0] s_data_b;

    logic [L-1:0]  model = '0;
    logic [LB-1:0] model_b = '0;

    always #5 clk = ~clk;

    ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(L)) dut (
        .prog_clk(clk), .pReset(p_reset), .start(start), .s_valid(s_valid),
        .s_data(s_data), .s_ready(s_ready), .config_enable(cfg_en),
        .ccff_head(head), .ccff_tail(tail), .busy(busy), .done(done), .err(err)
    );

    ccff_chain_loader #(.WORD_W(WB), .CHAIN_LEN(LB)) dut_b (
        .prog_clk(clk), .pReset(p_reset), .start(start_b), .s_valid(s_valid_b),
        .s_data(s_data_b), .s_ready(s_ready_b), .config_enable(en_b),
        .ccff_head(head_b), .ccff_tail(tail_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string what);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out, event never came", what);
    endtask

    // ---------------- chain models ----------------
    int corrupt_at = -1;
    int flipped_at = -1;
    int tot_shift  = 0;

    assign tail = model[0];

    always @(posedge clk) begin
        if (cfg_en) begin
            model <= {head, model[L-1:1]};
        end else if ((corrupt_at >= 0) && (tot_shift == corrupt_at) && (flipped_at != corrupt_at)) begin
            model[17]  <= ~model[17];
            flipped_at <= corrupt_at;
        end
    end

    always @(posedge clk) begin
        if (en_b) model_b <= {head_b, model_b[LB-1:1]};
        tail_b <= ~tail_b;
    end

    // ---------------- scoreboard / monitor ----------------
    logic exp_q[$];
    int   cyc = 0;
    int   shift_cyc [0:4095];
    int   last_shift_cyc = -1;
    int   done_tot = 0;
    int   done_cyc = -1;
    int   err_rise_shift = -1;
    logic err_prev = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (err && !err_prev) err_rise_shift = tot_shift;
        err_prev = err;
        if (done) begin
            done_tot = done_tot + 1;
            done_cyc = cyc;
        end
        if (cfg_en) begin
            if (tot_shift < 4096) shift_cyc[tot_shift] = cyc;
            last_shift_cyc = cyc;
            tot_shift = tot_shift + 1;
            if (exp_q.size() == 0) begin
                timeout_fail("head_unexpected_shift");
            end else begin
                check("head_bit", {63'd0, head}, {63'd0, exp_q.pop_front()});
            end
        end
    end

    int   shifts_b = 0;
    int   done_b_cnt = 0;
    int   last_shift_b = -1;
    int   done_b_cyc = -1;
    logic err_b_seen = 1'b0;

    always @(negedge clk) begin
        if (en_b) begin
            shifts_b = shifts_b + 1;
            last_shift_b = cyc;
        end
        if (done_b) begin
            done_b_cnt = done_b_cnt + 1;
            done_b_cyc = cyc;
        end
        if (err_b) err_b_seen = 1'b1;
    end

    // ---------------- scenario table ----------------
    typedef struct {
        string        name;
        logic [39:0]  words;
        int           stall_idx;
        int           stall_len;
        bit           start_mid;
        bit           corrupt;
        logic [L-1:0] exp_chain;
        int           exp_gaps;
    } vec_t;

    vec_t vecs [5];

    task automatic wait_ready(output bit ok);
        int n = 0;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = s_ready;
        if (!ok) timeout_fail("s_ready_wait");
    endtask

    task automatic send_pass(input logic [39:0] words, input int nw, input int stall_idx,
                             input int stall_len, input bit start_mid);
        int pushed = 0;
        bit ok;
        for (int i = 0; i < nw; i++) begin
            if (i == stall_idx) begin
                s_valid = 1'b0;
                wait_ready(ok);
                repeat (stall_len) @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = words[8*i +: 8];
            if (start_mid && i == 2) start = 1'b1;
            wait_ready(ok);
            if (!ok) begin
                s_valid = 1'b0;
                start   = 1'b0;
                return;
            end
            for (int b = 0; b < W; b++) begin
                if (pushed < L) exp_q.push_back(s_data[b]);
                pushed++;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_load(input int k);
        vec_t v;
        int   base, base_done, gaps, n;
        v = vecs[k];
        base      = tot_shift;
        base_done = done_tot;
        corrupt_at = (v.corrupt && VERIFY_EN) ? base + L : -1;
        pulse_start();
        check({v.name, "_ready_after_start"}, {63'd0, s_ready}, 64'd1);
        check({v.name, "_busy"}, {63'd0, busy}, 64'd1);
        check({v.name, "_err_cleared"}, {63'd0, err}, 64'd0);
        for (int p = 0; p < PASSES; p++) begin
            send_pass(v.words, NWORDS, (p == 0) ? v.stall_idx : -1, v.stall_len,
                      (p == 0) ? v.start_mid : 1'b0);
        end
        n = 0;
        while (done_tot == base_done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_tot == base_done) begin
            timeout_fail({v.name, "_done"});
            return;
        end
        gaps = shift_cyc[base + L - 1] - shift_cyc[base] + 1 - L;
        check({v.name, "_shift_count"}, 64'(tot_shift - base), 64'(L * PASSES));
        check({v.name, "_gaps"}, 64'(gaps), 64'(v.exp_gaps));
        check({v.name, "_done_pulses"}, 64'(done_tot - base_done), 64'd1);
        check({v.name, "_done_latency"}, 64'(done_cyc - last_shift_cyc), 64'd1);
        check({v.name, "_chain"}, 64'(model), 64'(v.exp_chain));
        check({v.name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        check({v.name, "_head_hold"}, {63'd0, head}, {63'd0, v.exp_chain[L-1]});
        check({v.name, "_err"}, {63'd0, err}, {63'd0, v.corrupt && VERIFY_EN});
        check({v.name, "_idle"}, {63'd0, busy}, 64'd0);
        if (v.corrupt && VERIFY_EN) begin
            check({v.name, "_err_rise"}, 64'(err_rise_shift), 64'(base + L + 18));
        end
        $display("load %s: shifts=%0d gaps=%0d chain=%0h err=%0b", v.name,
                 tot_shift - base, gaps, model, err);
    endtask

    initial begin
        bit ok;
        int base, n;

        vecs[0] = '{"basic",    40'h0B00FF3CA5, -1, 0, 1'b0, 1'b0, 36'hB00FF3CA5, 0};
        vecs[1] = '{"stall",    40'h0B00FF3CA5,  2, 7, 1'b0, 1'b0, 36'hB00FF3CA5, 7};
        vecs[2] = '{"start_mid",40'h0B00FF3CA5, -1, 0, 1'b1, 1'b0, 36'hB00FF3CA5, 0};
        vecs[3] = '{"alt_corr", 40'hF7AA558001,  4, 3, 1'b0, 1'b1, 36'h7AA558001, 3};
        vecs[4] = '{"reload",   40'h0B00FF3CA5, -1, 0, 1'b0, 1'b0, 36'hB00FF3CA5, 0};

        p_reset = 1'b1;
        start = 1'b0; s_valid = 1'b0; s_data = '0;
        start_b = 1'b0; s_valid_b = 1'b0; s_data_b = '0;
        repeat (3) @(posedge clk);
        #1;
        p_reset = 1'b0;
        @(posedge clk); #1;
        check("rst_s_ready", {63'd0, s_ready}, 64'd0);
        check("rst_cfg_en",  {63'd0, cfg_en},  64'd0);
        check("rst_head",    {63'd0, head},    64'd0);
        check("rst_busy",    {63'd0, busy},    64'd0);
        check("rst_done",    {63'd0, done},    64'd0);
        check("rst_err",     {63'd0, err},     64'd0);
        $display("reset: s_ready=%0b cfg_en=%0b busy=%0b done=%0b err=%0b",
                 s_ready, cfg_en, busy, done, err);

        for (int k = 0; k < 5; k++) run_load(k);

        // Reset in the middle of a load
        base = tot_shift;
        corrupt_at = -1;
        pulse_start();
        send_pass(vecs[0].words, 3, -1, 0, 1'b0);
        n = 0;
        while ((tot_shift - base) < 20 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if ((tot_shift - base) < 20) timeout_fail("midload_20_shifts");
        p_reset = 1'b1;
        @(posedge clk); #1;
        p_reset = 1'b0;
        check("midrst_cfg_en",  {63'd0, cfg_en},  64'd0);
        check("midrst_s_ready", {63'd0, s_ready}, 64'd0);
        check("midrst_busy",    {63'd0, busy},    64'd0);
        check("midrst_done",    {63'd0, done},    64'd0);
        @(negedge clk);
        exp_q.delete();
        $display("reset mid-load: shifts before reset=%0d busy=%0b", tot_shift - base, busy);
        @(posedge clk); #1;
        run_load(0);

`ifndef CCFF_READBACK_CHECK_EN
        // Narrow loader: 13-bit chain, 4-bit words, ccff_tail toggling
        @(posedge clk); #1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int i = 0; i < NWORDSB; i++) begin
            s_valid_b = 1'b1;
            s_data_b  = 4'(16'h3F69 >> (4 * i));
            n = 0;
            @(negedge clk);
            while (!s_ready_b && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!s_ready_b) timeout_fail("b_ready_wait");
            @(posedge clk); #1;
        end
        s_valid_b = 1'b0;
        n = 0;
        while (done_b_cnt == 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_b_cnt == 0) timeout_fail("b_done");
        repeat (3) @(posedge clk);
        #1;
        check("b_shift_count",  64'(shifts_b), 64'(LB));
        check("b_done_pulses",  64'(done_b_cnt), 64'd1);
        check("b_done_latency", 64'(done_b_cyc - last_shift_b), 64'd1);
        check("b_err_never",    {63'd0, err_b_seen}, 64'd0);
        check("b_chain",        64'(model_b), 64'h1F69);
        check("b_idle",         {63'd0, busy_b}, 64'd0);
        $display("load narrow: shifts=%0d chain=%0h err_seen=%0b", shifts_b, model_b, err_b_seen);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain driver sitting directly upstream of the routing tiles' `ccff_head`. It accepts bitstream words from the host/JTAG side over a valid/ready stream, serialises them LSB-first into the configuration flip-flop chain, and gates shifting with `config_enable`. Optionally it runs a second pass and compares `ccff_tail` to prove the chain loaded intact.

## Interface
Parameters:
- `WORD_W`, default 8: host word width.
- `CHAIN_LEN`, default 36: total chain bits; the default matches one cbx tile (9 muxes × 4 bits).
- `CNT_W`, default `$clog2(CHAIN_LEN+1)`: width of the bit counter.

Ports (name, direction, width, meaning):
- `prog_clk`, in, 1: single clock, shared with the chain.
- `pReset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begins a load; sampled only in IDLE.
- `s_valid`, in, 1: host word valid.
- `s_data`, in, `WORD_W`: host word, bit 0 shifted first.
- `s_ready`, out, 1: word accepted when `s_valid && s_ready`.
- `config_enable`, out, 1: chain shift enable, high exactly on shift cycles.
- `ccff_head`, out, 1: serial data into the chain.
- `ccff_tail`, in, 1: serial data out of the last chain flop.
- `busy`, out, 1: FSM is not in IDLE.
- `done`, out, 1: one-cycle pulse when the load (and verify, if enabled) completes.
- `err`, out, 1: sticky verify mismatch; cleared on `start`.

## Operation
- **FSM states:** IDLE → LOAD → (VERIFY) → DONE → IDLE.
- **IDLE:** `start` clears `err` and the bit counter, then moves to LOAD.
- **LOAD:**
  - The serializer holds one word buffer (`buf`, `buf_vld`, `bit_idx`).
  - `s_ready = !buf_vld || (shift && last bit of word)`, which gives back-to-back words with no bubble.
  - Shift condition: `buf_vld` is set and the total bit count is below `CHAIN_LEN`.
  - On a shift: `config_enable` = 1, `ccff_head` = `buf[bit_idx]`, the counter increments.
  - When the counter reaches `CHAIN_LEN`, the remaining bits of the final partial word are discarded, the buffer is cleared, and the FSM moves to VERIFY (macro defined) or DONE.
- **Host stall:** if `buf_vld` = 0, then `config_enable` = 0 and the chain holds. Stalls of any length are legal.
- **VERIFY:** the host re-sends the identical bitstream. On each shift, `ccff_tail` (pre-edge) is compared to the bit being shifted. Any mismatch sets `err`. Completes after `CHAIN_LEN` shifts.
- **DONE:** asserts `done` for one cycle, then returns to IDLE.
- `start` outside IDLE is ignored.
- `s_valid` outside LOAD/VERIFY is not accepted (`s_ready` = 0).
- **Reset mid-operation:** the FSM returns to IDLE, the buffer is cleared, and `config_enable` drops on the next edge. Chain contents are undefined; the host must restart.
- `config_enable`, `ccff_head`, `s_ready`, `busy`, `done` and `err` derive from registers only; there are no input-to-output combinational paths.

## Timing
- **Reset values:** state IDLE; `s_ready`, `config_enable`, `ccff_head`, `busy`, `done`, `err` = 0.
- **Handshake latency:** a word accepted at edge t produces its first shift (`config_enable` = 1) in cycle t+1.
- **Throughput:** one bit per cycle while data is available.
- **Minimum LOAD time:** `CHAIN_LEN` shift cycles plus 1 cycle from `start` to the first `s_ready`.
- **`done`:** rises 1 cycle after the final shift.
- **`ccff_head`:** valid only when `config_enable` = 1; otherwise it holds its last value.

## Configuration
- **`CCFF_READBACK_CHECK_EN` defined:** the VERIFY state, the tail comparator and `err` logic are compiled in.
- **Undefined:** LOAD goes straight to DONE, `err` is tied to 0, and `ccff_tail` is unused.

## Structure
- **Package `ccff_loader_pkg`:** FSM state enum (`ST_IDLE`, `ST_LOAD`, `ST_VERIFY`, `ST_DONE`) and a words-per-chain helper function `ceil(CHAIN_LEN/WORD_W)`.
- **Sub-module `ccff_word_serializer`:** word buffer, `bit_idx`, `s_ready` generation and the `shift` strobe. The top level holds the FSM, the total counter and the verify logic.

## Test plan
Unless noted, use `WORD_W`=8, `CHAIN_LEN`=36, with a 36-flop shift-register model on `ccff_head`/`ccff_tail`.
- **Basic load:** `start`, then 5 words `0xA5, 0x3C, 0xFF, 0x00, 0x0B` back-to-back.
  - Expect exactly 36 `config_enable` cycles with no gaps.
  - The model holds bits 0–35 in order; the upper 4 bits of `0x0B` are never shifted.
  - `done` pulses once, 1 cycle after the last shift.
- **Host stall:** hold `s_valid` low for 7 cycles between words 2 and 3.
  - `config_enable` = 0 for exactly those cycles.
  - Final chain contents match the basic-load case.
- **Verify pass (macro defined):** re-send the identical 5 words.
  - `err` = 0, and `done` follows 36 verify shifts.
  - Corrupting bit 17 in the model before VERIFY causes `err` = 1 from the mismatching shift onward; `err` is still set at `done`.
- **Ignored `start`:** assert `start` during LOAD.
  - The counter is not reset and behaviour is unchanged.
  - A `start` after `done` begins a new load and clears `err`.
- **Reset mid-load:** pulse `pReset` after 20 shifts.
  - Next cycle: IDLE, `config_enable` = 0, `s_ready` = 0, `busy` = 0.
  - A subsequent full load succeeds.
- **Macro undefined:** `CHAIN_LEN`=13, `WORD_W`=4, 4 words.
  - 13 shifts occur, then `done`.
  - `err` stays 0, and toggling `ccff_tail` has no effect.
